// File: rtl/fc_arbiter.sv
// Round-robin arbiter and pause generator that drains the input-class FIFOs
// into the single output FIFO. It grants at most one input pop per cycle,
// registers the push toward the output FIFO, and keeps a pause flag with
// hysteresis driven by the output FIFO status.
module fc_arbiter #(
    parameter int FIFO_COUNT = 5,
    parameter int DATA_WIDTH = 6
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   enb,
    input  logic [FIFO_COUNT-2:0]                  empty_in,
    input  logic [(FIFO_COUNT-1)*DATA_WIDTH-1:0]   data_in,
    input  logic                                   out_almost_full,
    input  logic                                   out_almost_empty,
    input  logic                                   out_full,
    output logic [FIFO_COUNT-2:0]                  pop,
    output logic                                   push_out,
    output logic [DATA_WIDTH-1:0]                  data_out,
    output logic [FIFO_COUNT-2:0]                  continuar,
    output logic                                   pause,
    output logic [1:0]                             state
);

    // Number of input FIFOs; the output FIFO is the last index overall.
    localparam int N = FIFO_COUNT - 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_PAUSE  = 2'd2
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;
    logic [N-1:0]           ptr_reg;
    logic                   pause_reg;
    logic                   pause_next;
    logic                   push_reg;
    logic [DATA_WIDTH-1:0]  data_reg;

    logic [N-1:0]           req;
    logic [N-1:0]           grant;
    logic [N-1:0]           pop_int;
    logic                   pop_any;
    logic [DATA_WIDTH-1:0]  data_sel;
    logic                   pause_set;
    logic                   pause_clr;
    int                     ptr_idx;

    // Per-input request and enable bits: a request is a non-empty FIFO, and
    // every input is enabled exactly when the arbiter is not paused.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_bit
            assign req[gi]       = ~empty_in[gi];
            assign continuar[gi] = ~pause_reg;
        end
    endgenerate

    // Encode the one-hot grant pointer into an index.
    always_comb begin
        ptr_idx = 0;
        for (int i = 0; i < N; i++) begin
            if (ptr_reg[i]) begin
                ptr_idx = i;
            end
        end
    end

    // Round-robin search: first requesting input after the last grant, with wrap.
    always_comb begin
        grant = '0;
        for (int k = N; k >= 1; k--) begin
            if (req[(ptr_idx + k) % N]) begin
                grant = '0;
                grant[(ptr_idx + k) % N] = 1'b1;
            end
        end
    end

    // Pop is suppressed during reset, when disabled, paused, or output is full.
    assign pop_int = (rst && enb && !pause_reg && !out_full) ? grant : '0;
    assign pop_any = |pop_int;

    // Select the head word of the winning input.
    always_comb begin
        data_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                data_sel = data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Pause hysteresis: set on almost-full/full, clear on almost-empty, set wins.
    assign pause_set = out_almost_full | out_full;
    assign pause_clr = out_almost_empty & ~out_full;

    always_comb begin
        pause_next = pause_reg;
        if (pause_set) begin
            pause_next = 1'b1;
        end else if (pause_clr) begin
            pause_next = 1'b0;
        end
    end

    // Next-state logic: pause dominates, otherwise activity follows the pop.
    always_comb begin
        state_next = state_reg;
        if (enb) begin
            if (pause_next) begin
                state_next = ST_PAUSE;
            end else if (pop_any) begin
                state_next = ST_ACTIVE;
            end else begin
                state_next = ST_IDLE;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Pointer, pause and push datapath registers; all frozen while disabled
    // except the push strobe, which drops so nothing is written twice.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_reg   <= N'(1) << (N - 1);
            pause_reg <= 1'b0;
            push_reg  <= 1'b0;
            data_reg  <= '0;
        end else if (enb) begin
            pause_reg <= pause_next;
            push_reg  <= pop_any;
            if (pop_any) begin
                ptr_reg  <= pop_int;
                data_reg <= data_sel;
            end
        end else begin
            push_reg <= 1'b0;
        end
    end

    assign pop      = pop_int;
    assign push_out = push_reg;
    assign data_out = data_reg;
    assign pause    = pause_reg;
    assign state    = state_reg;

endmodule

// File: doc/fc_arbiter.md
# fc_arbiter

Round-robin arbiter and pause generator that drains the four input-class FIFOs into the single output FIFO. Sits directly upstream of the flow-control stage: its `continuar` vector drives that stage's `continuar` input (the per-FIFO enable), and it consumes the output FIFO's full and almost-full/almost-empty status. It keeps a registered pause with hysteresis and grants at most one input pop per cycle.

## Interface
- `FIFO_COUNT`, 5: total FIFOs; inputs are the `FIFO_COUNT-1` = 4 lowest indices, the output FIFO is the last.
- `DATA_WIDTH`, 6: word width.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `enb` in 1: global enable; 0 freezes all state.
- `empty_in` in FIFO_COUNT-1: empty flag of each input FIFO.
- `data_in` in (FIFO_COUNT-1)*DATA_WIDTH: head word of each input FIFO (first-word-fall-through); input i is at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `out_almost_full` in 1: output FIFO almost-full flag.
- `out_almost_empty` in 1: output FIFO almost-empty flag.
- `out_full` in 1: output FIFO full flag.
- `pop` out FIFO_COUNT-1: one-hot or zero; the granted input FIFO pops at this edge.
- `push_out` out 1: registered write strobe to the output FIFO.
- `data_out` out DATA_WIDTH: registered word written with `push_out`.
- `continuar` out FIFO_COUNT-1: per-input enable, all bits = ~pause.
- `pause` out 1: registered pause flag.
- `state` out 2: 0 IDLE, 1 ACTIVE, 2 PAUSE.

## Operation
- Reset (`rst`=0, immediate): `pop`=0, `push_out`=0, `data_out`=0, `pause`=0, `continuar`=all ones, `state`=IDLE. The grant pointer is set to one-hot index FIFO_COUNT-2, so input 0 has first priority.
- Pause register, updated each edge when `enb`=1:
  - set when `out_almost_full`=1 or `out_full`=1;
  - cleared only when `out_almost_empty`=1 and `out_full`=0;
  - otherwise held (hysteresis);
  - if set and clear conditions are both true in one cycle, set wins.
- `pop` is combinational:
  - it is nonzero only when `enb`=1, `pause`=0, `out_full`=0 and at least one `empty_in` bit is 0;
  - the winner is the first non-empty input searching upward (with wrap) from the index after the last grant.
- On every edge where `pop`≠0, the grant pointer updates to the winner. Otherwise it holds.
- Datapath: `push_out` and `data_out` are registered from `pop` and the winner's `data_in` at the same edge. When `push_out`=0, `data_out` holds its last value.
- State, registered:
  - PAUSE if the next `pause`=1;
  - else ACTIVE if a pop occurs this cycle;
  - else IDLE.
- Transitions:
  - IDLE→ACTIVE on any non-empty input;
  - ACTIVE→IDLE when all inputs are empty;
  - any state→PAUSE on the set condition;
  - PAUSE→IDLE/ACTIVE on the clear condition.
- `enb`=0:
  - `pop`=0;
  - `push_out` is 0 at the next edge;
  - pause, pointer, state and `data_out` are held.
- Output FIFO contract: because a pop in cycle N pushes in N+1 and pause is registered, up to 2 words may arrive after `out_almost_full` rises. The output FIFO's almost-full threshold must therefore be ≤ depth-2.
- Reset mid-operation aborts any in-flight push (`push_out` forced to 0). No word is duplicated, but a popped word still in flight is lost; this is by design.

## Timing
- Pop-to-push latency: 1 cycle. Pop in cycle N gives `push_out`=1 with the winner's word in cycle N+1.
- Pause latency:
  - flag asserted in cycle N gives `pause`=1, `continuar`=0 and `pop`=0 from cycle N+1;
  - `out_full` blocks `pop` in the same cycle N.
- Release: `out_almost_empty`=1 in cycle M gives `pause`=0 in M+1; the first pop can occur in M+1.
- Throughput: 1 word/cycle while unpaused and any input is non-empty.

## Test plan
- Reset: assert `rst`=0 mid-traffic while `pop`=0010 → `pop`=0, `push_out`=0, `data_out`=0, `continuar`=1111, `state`=0, all without waiting for a clock edge. After release, with all inputs non-empty, the first `pop`=0001.
- Single source: only input 2 is non-empty with heads 0x11, 0x12 → `pop`=0100 for two cycles. `push_out`=1 with `data_out`=0x11 then 0x12, each one cycle later. Then `state`=IDLE.
- Fairness: all four inputs are non-empty for 6 cycles → `pop` = 0001, 0010, 0100, 1000, 0001, 0010. If input 1 goes empty, the sequence skips it: 0001, 0100.
- Hysteresis: `out_almost_full`=1 in cycle 10 for one cycle, `out_almost_empty`=1 in cycle 15 → `pause`=1, `state`=2, `continuar`=0000 and `pop`=0 for cycles 11–15; the first pop occurs in cycle 16. Asserting both flags in the same cycle keeps `pause` set.
- Full guard: `out_full`=1 in cycle N while ACTIVE → `pop`=0 in cycle N, and `pause`=1 from N+1.
- Enable: `enb`=0 for 3 cycles after a grant to input 1 → `pop`=0 throughout and `push_out`=0 one edge later. On resume the next grant is input 2.
